// File: rtl/muldiv_controller.sv
// rtl/muldiv_controller.sv - HI/LO multiply/divide sequencer (shift-add multiply, restoring divide)
// Long ops take WIDTH iterations plus a sign-fix and a result cycle; mthi/mtlo write directly.
module muldiv_controller #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  // acc: multiply = {partial product, remaining multiplier}; divide = {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   op_m;
  logic [WIDTH-1:0]   a_raw;
  logic               neg_a;
  logic               neg_b;
  logic               is_div;

  logic               signed_in;
  logic               neg_a_in;
  logic               neg_b_in;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH-1:0]   diff;
  logic               ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    signed_in = (Funct == F_MULT) || (Funct == F_DIV);
    neg_a_in  = signed_in & in_a[WIDTH-1];
    neg_b_in  = signed_in & in_b[WIDTH-1];
    mag_a     = neg_a_in ? ('0 - in_a) : in_a;
    mag_b     = neg_b_in ? ('0 - in_b) : in_b;

    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? op_m : '0)};

    rem_shift = acc[2*WIDTH-1:WIDTH-1];
    ge        = rem_shift >= {1'b0, op_m};
    diff      = rem_shift[WIDTH-1:0] - op_m;

    prod_fix  = (neg_a ^ neg_b) ? ('0 - acc) : acc;
    quot_fix  = (neg_a ^ neg_b) ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    rem_fix   = neg_a ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      acc    <= '0;
      op_m   <= '0;
      a_raw  <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      is_div <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (Funct)
              F_MULT, F_MULTU: begin
                acc    <= {{WIDTH{1'b0}}, mag_b};
                op_m   <= mag_a;
                neg_a  <= neg_a_in;
                neg_b  <= neg_b_in;
                is_div <= 1'b0;
                cnt    <= '0;
                busy   <= 1'b1;
                state  <= MUL;
              end
              F_DIV, F_DIVU: begin
                acc    <= {{WIDTH{1'b0}}, mag_a};
                op_m   <= mag_b;
                a_raw  <= in_a;
                neg_a  <= neg_a_in;
                neg_b  <= neg_b_in;
                is_div <= 1'b1;
                cnt    <= '0;
                busy   <= 1'b1;
                state  <= DIV;
              end
              F_MTHI:  hi <= in_a;
              F_MTLO:  lo <= in_a;
              default: ;
            endcase
          end
        end
        MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        DIV: begin
          acc <= {(ge ? diff : rem_shift[WIDTH-1:0]), acc[WIDTH-2:0], ge};
          cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          // Results land on this edge so they are visible together with done in the DONE cycle.
          if (!is_div) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (op_m == '0) begin
            hi <= a_raw;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quot_fix;
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
